// File: rtl/rfsoc_config_pkg.sv
// ============================================================================
// rfsoc_config : shared RFSoC PS-side configuration types and constants
// Revision     : 1.1 - readback pattern generator enums added
// ============================================================================
`default_nettype none

package rfsoc_config;

    // GPIO bit used as the software trigger for PS-side test sources
    localparam int sdata = 0;

    typedef enum logic [1:0] {
        RB_NIBBLE  = 2'd0,
        RB_INCR    = 2'd1,
        RB_WALK1   = 2'd2,
        RB_CHECKER = 2'd3
    } readback_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_STREAM       = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } readback_state_t;

    // Index width that stays legal for a single-beat burst
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/readback_pattern_core.sv
// ============================================================================
// readback_pattern_core : combinational beat-pattern generator
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module readback_pattern_core
    import rfsoc_config::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  readback_mode_t      mode,
    input  logic [IDX_W-1:0]    beat_idx,
    output logic [DATA_W-1:0]   pattern
);

    logic [DATA_W-1:0] idx_ext;
    logic [DATA_W-1:0] one;
    logic [31:0]       shamt;

    assign idx_ext = DATA_W'(beat_idx);
    assign one     = {{(DATA_W-1){1'b0}}, 1'b1};
    assign shamt   = 32'(beat_idx) % 32'(DATA_W);

    always_comb begin
        pattern = '0;
        unique case (mode)
            RB_NIBBLE:  pattern = {(DATA_W/4){idx_ext[3:0]}};
            RB_INCR:    pattern = idx_ext;
            RB_WALK1:   pattern = one << shamt;
            RB_CHECKER: pattern = beat_idx[0] ? {(DATA_W/8){8'hAA}} : {(DATA_W/8){8'h55}};
            default:    pattern = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axis_readback_pattern_gen.sv
// ============================================================================
// axis_readback_pattern_gen : GPIO-triggered AXI-Stream burst test source
//   Optional macro READBACK_SEQ_EN puts a burst sequence number in the top byte.
// Revision                  : 2.0 - parametrised width/length, four patterns
// ============================================================================
`default_nettype none

module axis_readback_pattern_gen
    import rfsoc_config::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int MODE_LSB  = 1
) (
    input  logic              ps_clk,
    input  logic              rst,
    input  logic [15:0]       gpio_in,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W    = idx_width(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    generate
        if (MODE_LSB < 0 || MODE_LSB > 14 || MODE_LSB == sdata || MODE_LSB + 1 == sdata) begin : g_bad_mode_lsb
            $error("MODE_LSB field overlaps the trigger bit or leaves gpio_in");
        end
    endgenerate

    readback_state_t   state, state_n;
    readback_mode_t    mode_q, mode_n, pat_mode, gpio_mode;
    logic [IDX_W-1:0]  beat_idx, idx_n, pat_idx;
    logic [DATA_W-1:0] pattern, beat_data, tdata_n;
    logic              tvalid_n, tlast_n, done_n;
    logic              trig;
    logic              unused_gpio;

    assign trig        = gpio_in[sdata];
    assign gpio_mode   = readback_mode_t'(gpio_in[MODE_LSB+1:MODE_LSB]);
    assign unused_gpio = ^gpio_in;
    assign busy        = (state == ST_STREAM);

    readback_pattern_core #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_core (
        .mode     (pat_mode),
        .beat_idx (pat_idx),
        .pattern  (pattern)
    );

`ifdef READBACK_SEQ_EN
    logic [7:0] seq_cnt;
    logic [7:0] seq_lat;

    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            seq_cnt <= 8'd0;
            seq_lat <= 8'd0;
        end else begin
            if (done)
                seq_cnt <= seq_cnt + 8'd1;
            if (state == ST_IDLE && trig)
                seq_lat <= seq_cnt;
        end
    end

    // Beat 0 is loaded on the trigger edge, before seq_lat has captured the count
    always_comb begin
        beat_data                  = pattern;
        beat_data[DATA_W-1 -: 8]   = (state == ST_IDLE) ? seq_cnt : seq_lat;
    end
`else
    assign beat_data = pattern;
`endif

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        idx_n    = beat_idx;
        tdata_n  = m_axis_tdata;
        tvalid_n = m_axis_tvalid;
        tlast_n  = m_axis_tlast;
        done_n   = 1'b0;
        pat_mode = mode_q;
        pat_idx  = beat_idx + IDX_W'(1);
        unique case (state)
            ST_IDLE: begin
                pat_mode = gpio_mode;
                pat_idx  = '0;
                if (trig) begin
                    state_n  = ST_STREAM;
                    mode_n   = gpio_mode;
                    idx_n    = '0;
                    tdata_n  = beat_data;
                    tvalid_n = 1'b1;
                    tlast_n  = (LAST_IDX == '0);
                end
            end
            ST_STREAM: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (beat_idx == LAST_IDX) begin
                        state_n  = ST_WAIT_RELEASE;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                        done_n   = 1'b1;
                    end else begin
                        idx_n    = beat_idx + IDX_W'(1);
                        tdata_n  = beat_data;
                        tlast_n  = ((beat_idx + IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (!trig)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            mode_q        <= RB_NIBBLE;
            beat_idx      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            mode_q        <= mode_n;
            beat_idx      <= idx_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            done          <= done_n;
        end
    end

endmodule

`default_nettype wire

// File: doc/axis_readback_pattern_gen.md
Name: axis_readback_pattern_gen

Overview:
- Parametrised CPU-readback test source for the PS-side AXI-Stream readback path.
- On a GPIO trigger it emits one burst of BURST_LEN beats in a CPU-selected pattern, with tlast on the final beat.
- Drives the readback DMA/FIFO input directly, using full AXI-Stream backpressure; no beats are dropped.
- Supersedes the fixed 16-beat, 32-bit, single-pattern tester.

Parameters:
- DATA_W, 32: tdata width; multiple of 8, range 8..256.
- BURST_LEN, 16: beats per burst, 1..256.
- MODE_LSB, 1: LSB of the 2-bit pattern-mode field in gpio_in; bits MODE_LSB and MODE_LSB+1 must not equal the trigger bit (elaboration-time assertion).

Ports:
- ps_clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- gpio_in  in  16  CPU GPIO; bit rfsoc_config::sdata is the trigger; gpio_in[MODE_LSB+1:MODE_LSB] is the mode.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on beat BURST_LEN-1.
- busy  out  1  high in ST_STREAM.
- done  out  1  one-cycle pulse when the last beat is accepted.

Behaviour:
- Reset (async assert, sync release): state=ST_IDLE; all outputs 0; beat index 0; mode register 0.
- Transfer: a beat transfers when tvalid && tready.
- Output register: tdata, tvalid and tlast are registered. Once tvalid=1, tdata and tlast hold until the beat transfers.
- Throughput: with tready held high, one beat per cycle.
- ST_IDLE -> ST_STREAM when gpio_in[sdata]=1 is sampled. On that same edge:
  - latch mode;
  - load beat 0 into the output register;
  - set tvalid=1 and busy=1.
  - Latency: first beat visible 1 cycle after the trigger is sampled.
- ST_STREAM, on each transfer of beat i:
  - if i < BURST_LEN-1: load beat i+1 on the same edge (no bubble);
  - if i = BURST_LEN-1: tvalid<=0, tlast<=0, done<=1 for one cycle, go to ST_WAIT_RELEASE.
- ST_WAIT_RELEASE -> ST_IDLE when gpio_in[sdata]=0. A trigger held high never starts a second burst.
- Trigger dropped mid-burst: ignored; the burst always completes.
- Mode change mid-burst: ignored; the mode is latched only at trigger.
- Patterns, by beat index i (width clog2(BURST_LEN), zero-extended):
  - mode 0 (legacy): i[3:0] replicated DATA_W/4 times.
  - mode 1 (incrementing): i zero-extended to DATA_W.
  - mode 2 (walking-one): 1 << (i mod DATA_W).
  - mode 3 (checkerboard): {DATA_W/8{8'h55}} for even i, {DATA_W/8{8'hAA}} for odd i.
- BURST_LEN=1: beat 0 carries tlast=1 and is the only beat.
- Reset mid-burst: tvalid drops immediately. A partial burst is acceptable only under reset.

Optional Feature:
- Macro: READBACK_SEQ_EN.
- Defined:
  - an 8-bit burst sequence counter (reset 0) increments on each done pulse and wraps 255->0;
  - m_axis_tdata[DATA_W-1:DATA_W-8] carries the sequence value latched at trigger, replacing those pattern bits on every beat of the burst.
- Undefined: no counter; tdata is the pure pattern.

Decomposition:
- Package rfsoc_config additions:
  - typedef enum logic [1:0] readback_mode_t {RB_NIBBLE, RB_INCR, RB_WALK1, RB_CHECKER};
  - state enum readback_state_t {ST_IDLE, ST_STREAM, ST_WAIT_RELEASE};
  - existing sdata is reused.
- One natural sub-module: readback_pattern_core, combinational; inputs mode and beat index, output DATA_W pattern; parametrised by DATA_W.
- FSM and output register stay in the top module.

Test Plan:
- DATA_W=32, BURST_LEN=16, mode 0, tready=1, trigger high -> 16 consecutive beats 0x00000000..0xFFFFFFFF (nibble i replicated), tlast on beat 15, one done pulse.
- Mode 1, tready toggled every other cycle -> beats 0..15 in order, no loss or duplication, tdata stable while tvalid && !tready.
- Trigger held high for 100 cycles, then low, then high -> exactly 2 bursts total.
- DATA_W=64, BURST_LEN=70, mode 2 -> beat 64 = 0x1, beat 69 = 0x20, tlast on beat 69; mode 3 -> 0x5555..., 0xAAAA... alternating.
- Trigger dropped at beat 5, and separately rst asserted at beat 5 -> first case completes 16 beats; second has tvalid=0 immediately and the next trigger restarts at beat 0.
- With READBACK_SEQ_EN, 3 bursts, DATA_W=32 -> every beat's top byte is 0x00, 0x01, 0x02 for bursts 1, 2, 3 respectively.
